// File: rtl/mem_sched.sv
// mem_sched: shares one memory port between the CPU fetch and load/store requesters,
// with one-entry pending buffers, a bounded fetch starvation window and a per-transaction watchdog.
module mem_sched #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [15:0] WD_MAX     = 16'(TIMEOUT);

  state_t      state_r, state_next_s;
  logic        owner_d_r, owner_d_next_s;
  logic [3:0]  starve_r, starve_next_s;
  logic [15:0] wd_r, wd_next_s;

  logic        i_full_r, i_instr_r;
  logic [31:0] i_addr_r, i_wdata_r;
  logic [3:0]  i_wstrb_r;
  logic        d_full_r, d_instr_r;
  logic [31:0] d_addr_r, d_wdata_r;
  logic [3:0]  d_wstrb_r;

  logic busy_s, resp_s, timeout_s, done_s, i_done_s, d_done_s;
  logic i_cap_s, d_cap_s, i_avail_s, d_avail_s, arb_s, grant_i_s, grant_d_s;

  // Completion, capture and arbitration; a side's buffer can refill on its own completion cycle.
  always_comb begin
    busy_s    = (state_r == ST_REQ) || (state_r == ST_WAIT);
    resp_s    = busy_s && memory_ready;
    timeout_s = (state_r == ST_WAIT) && (wd_r >= WD_MAX) && !memory_ready;
    done_s    = resp_s || timeout_s;
    i_done_s  = done_s && !owner_d_r;
    d_done_s  = done_s && owner_d_r;
    i_cap_s   = imemory_valid && (!i_full_r || i_done_s);
    d_cap_s   = dmemory_valid && (!d_full_r || d_done_s);
    i_avail_s = (i_full_r && !i_done_s) || i_cap_s;
    d_avail_s = (d_full_r && !d_done_s) || d_cap_s;
    arb_s     = (state_r == ST_IDLE) || done_s;
    grant_i_s = arb_s && i_avail_s && (!d_avail_s || (starve_r >= STARVE_MAX));
    grant_d_s = arb_s && d_avail_s && !grant_i_s;
  end

  // Next state of the port FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_i_s || grant_d_s) state_next_s = ST_REQ;
        else                        state_next_s = ST_IDLE;
      end
      ST_REQ, ST_WAIT: begin
        if (grant_i_s || grant_d_s) state_next_s = ST_REQ;
        else if (done_s)            state_next_s = ST_IDLE;
        else                        state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Owner, starvation counter and watchdog updates.
  always_comb begin
    owner_d_next_s = owner_d_r;
    starve_next_s  = starve_r;
    wd_next_s      = wd_r;
    if (grant_i_s) begin
      owner_d_next_s = 1'b0;
      starve_next_s  = 4'd0;
      wd_next_s      = 16'd0;
    end else if (grant_d_s) begin
      owner_d_next_s = 1'b1;
      wd_next_s      = 16'd0;
      if (i_avail_s && (starve_r < STARVE_MAX)) starve_next_s = starve_r + 4'd1;
      else                                      starve_next_s = starve_r;
    end else if ((state_r == ST_WAIT) && !done_s && (wd_r != 16'hFFFF)) begin
      wd_next_s = wd_r + 16'd1;
    end else begin
      wd_next_s = wd_r;
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      owner_d_r <= 1'b0;
      starve_r  <= 4'd0;
      wd_r      <= 16'd0;
    end else begin
      state_r   <= state_next_s;
      owner_d_r <= owner_d_next_s;
      starve_r  <= starve_next_s;
      wd_r      <= wd_next_s;
    end
  end

  // Pending request buffers, one per side.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_full_r  <= 1'b0;
      i_instr_r <= 1'b0;
      i_addr_r  <= 32'd0;
      i_wdata_r <= 32'd0;
      i_wstrb_r <= 4'd0;
      d_full_r  <= 1'b0;
      d_instr_r <= 1'b0;
      d_addr_r  <= 32'd0;
      d_wdata_r <= 32'd0;
      d_wstrb_r <= 4'd0;
    end else begin
      if (i_cap_s) begin
        i_full_r  <= 1'b1;
        i_instr_r <= imemory_instr;
        i_addr_r  <= imemory_addr;
        i_wdata_r <= imemory_wdata;
        i_wstrb_r <= imemory_wstrb;
      end else if (i_done_s) begin
        i_full_r  <= 1'b0;
      end
      if (d_cap_s) begin
        d_full_r  <= 1'b1;
        d_instr_r <= dmemory_instr;
        d_addr_r  <= dmemory_addr;
        d_wdata_r <= dmemory_wdata;
        d_wstrb_r <= dmemory_wstrb;
      end else if (d_done_s) begin
        d_full_r  <= 1'b0;
      end
    end
  end

  // Port and response outputs; a watchdog completion returns zero data.
  always_comb begin
    memory_valid = (state_r == ST_REQ);
    if (busy_s && owner_d_r) begin
      memory_instr = d_instr_r;
      memory_addr  = d_addr_r;
      memory_wdata = d_wdata_r;
      memory_wstrb = d_wstrb_r;
    end else if (busy_s) begin
      memory_instr = i_instr_r;
      memory_addr  = i_addr_r;
      memory_wdata = i_wdata_r;
      memory_wstrb = i_wstrb_r;
    end else begin
      memory_instr = 1'b0;
      memory_addr  = 32'd0;
      memory_wdata = 32'd0;
      memory_wstrb = 4'd0;
    end
    imemory_ready = i_done_s;
    dmemory_ready = d_done_s;
    if (resp_s && !owner_d_r) imemory_rdata = memory_rdata;
    else                      imemory_rdata = 32'd0;
    if (resp_s && owner_d_r)  dmemory_rdata = memory_rdata;
    else                      dmemory_rdata = 32'd0;
    bus_error = timeout_s;
  end

endmodule

// File: tb/tb_mem_sched.sv
// Scoreboard bench for mem_sched: stimulus queues expected grants and responses,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_mem_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        imemory_valid, imemory_instr, dmemory_valid, dmemory_instr;
  logic [31:0] imemory_addr, imemory_wdata, dmemory_addr, dmemory_wdata;
  logic [3:0]  imemory_wstrb, dmemory_wstrb;
  logic [31:0] imemory_rdata, dmemory_rdata;
  logic        imemory_ready, dmemory_ready;
  logic        memory_valid, memory_instr;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0]  memory_wstrb;
  logic        memory_ready, bus_error;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } grant_t;

  typedef struct {
    logic        side_d;
    logic [31:0] rdata;
    logic        berr;
    int          cyc;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     resp_lat = -1;
  int     cnt = -1;
  logic   stray_pending = 1'b0;
  logic [31:0] resp_data = 32'd0;
  int     t0;

  mem_sched #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .imemory_valid(imemory_valid), .imemory_instr(imemory_instr), .imemory_addr(imemory_addr),
    .imemory_wdata(imemory_wdata), .imemory_wstrb(imemory_wstrb), .imemory_rdata(imemory_rdata),
    .imemory_ready(imemory_ready),
    .dmemory_valid(dmemory_valid), .dmemory_instr(dmemory_instr), .dmemory_addr(dmemory_addr),
    .dmemory_wdata(dmemory_wdata), .dmemory_wstrb(dmemory_wstrb), .dmemory_rdata(dmemory_rdata),
    .dmemory_ready(dmemory_ready),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] v);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event with value %0h, required none", name, v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_grant(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int c);
    grant_t g;
    g.instr = instr; g.addr = addr; g.wdata = wdata; g.wstrb = wstrb; g.cyc = c;
    gq.push_back(g);
  endtask

  task automatic exp_resp(input logic side_d, input logic [31:0] rdata, input logic berr, input int c);
    resp_t r;
    r.side_d = side_d; r.rdata = rdata; r.berr = berr; r.cyc = c;
    rq.push_back(r);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((gq.size() != 0 || rq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (gq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d grants and %0d responses outstanding, required 0",
               name, gq.size(), rq.size());
      gq.delete();
      rq.delete();
    end
  endtask

  task automatic stray_check(input string name);
    @(negedge clock);
    stray_pending = 1'b1;
    @(negedge clock);
    chk({name, "_iready"}, 64'(imemory_ready), 64'd0);
    chk({name, "_dready"}, 64'(dmemory_ready), 64'd0);
    chk({name, "_berr"}, 64'(bus_error), 64'd0);
  endtask

  // Decoder model: answers resp_lat cycles after the REQ cycle (-1 never), or one stray pulse.
  initial begin
    memory_ready = 1'b0;
    memory_rdata = 32'hFFFF_FFFF;
    forever begin
      @(posedge clock);
      #1;
      memory_ready = 1'b0;
      memory_rdata = 32'hFFFF_FFFF;
      if (memory_valid) cnt = 0;
      else if (cnt >= 0 && cnt < 64) cnt = cnt + 1;
      else cnt = -1;
      if (cnt >= 0 && cnt == resp_lat) begin
        memory_ready = 1'b1;
        memory_rdata = resp_data;
        cnt = -1;
      end else if (stray_pending) begin
        memory_ready = 1'b1;
        memory_rdata = 32'h0BAD_0BAD;
        stray_pending = 1'b0;
      end
    end
  end

  // Monitor: compares every grant and every completion against the scoreboard.
  initial begin : monitor
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (memory_valid) begin
          if (gq.size() == 0) begin
            fail_evt("grant_unexpected", memory_addr);
          end else begin
            g = gq.pop_front();
            chk("grant_addr", 64'(memory_addr), 64'(g.addr));
            chk("grant_instr", 64'(memory_instr), 64'(g.instr));
            chk("grant_wdata", 64'(memory_wdata), 64'(g.wdata));
            chk("grant_wstrb", 64'(memory_wstrb), 64'(g.wstrb));
            chk("grant_cycle", 64'(cyc), 64'(g.cyc));
          end
        end
        if (imemory_ready || dmemory_ready) begin
          if (rq.size() == 0) begin
            fail_evt("resp_unexpected", memory_addr);
          end else begin
            r = rq.pop_front();
            chk("resp_side", 64'(dmemory_ready), 64'(r.side_d));
            chk("resp_both", 64'(imemory_ready && dmemory_ready), 64'd0);
            chk("resp_rdata", 64'(r.side_d ? dmemory_rdata : imemory_rdata), 64'(r.rdata));
            chk("resp_other_rdata", 64'(r.side_d ? imemory_rdata : dmemory_rdata), 64'd0);
            chk("resp_berr", 64'(bus_error), 64'(r.berr));
            chk("resp_cycle", 64'(cyc), 64'(r.cyc));
          end
        end else if (bus_error) begin
          fail_evt("berr_without_ready", memory_addr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    imemory_valid = 1'b0; imemory_instr = 1'b0; imemory_addr = 32'd0;
    imemory_wdata = 32'd0; imemory_wstrb = 4'd0;
    dmemory_valid = 1'b0; dmemory_instr = 1'b0; dmemory_addr = 32'd0;
    dmemory_wdata = 32'd0; dmemory_wstrb = 4'd0;
    #2;
    chk("rst_mvalid", 64'(memory_valid), 64'd0);
    chk("rst_maddr", 64'(memory_addr), 64'd0);
    chk("rst_iready", 64'(imemory_ready), 64'd0);
    chk("rst_dready", 64'(dmemory_ready), 64'd0);
    chk("rst_berr", 64'(bus_error), 64'd0);
    chk("rst_starve", 64'(dut.starve_r), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // 1: single fetch, ready two cycles after REQ
    resp_lat = 2; resp_data = 32'hDEAD_BEEF;
    tick(); t0 = cyc;
    exp_grant(1'b1, 32'h0000_0100, 32'd0, 4'd0, t0 + 1);
    exp_resp(1'b0, 32'hDEAD_BEEF, 1'b0, t0 + 3);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0100;
    tick();
    imemory_valid = 1'b0;
    drain("t1", 40);
    chk("t1_idle", 64'(dut.state_r), 64'd0);
    repeat (2) tick();

    // 2: simultaneous requests, data side first, fetch right after it completes
    resp_lat = 1; resp_data = 32'h0000_1111;
    tick(); t0 = cyc;
    exp_grant(1'b0, 32'h0000_0300, 32'h1234_5678, 4'hF, t0 + 1);
    exp_grant(1'b1, 32'h0000_0200, 32'd0, 4'd0, t0 + 3);
    exp_resp(1'b1, 32'h0000_1111, 1'b0, t0 + 2);
    exp_resp(1'b0, 32'h0000_1111, 1'b0, t0 + 4);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0200;
    dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = 32'h0000_0300;
    dmemory_wdata = 32'h1234_5678; dmemory_wstrb = 4'hF;
    tick();
    imemory_valid = 1'b0; dmemory_valid = 1'b0; dmemory_wdata = 32'd0; dmemory_wstrb = 4'd0;
    drain("t2", 40);
    repeat (2) tick();

    // 3: starvation, data re-requests on every completion cycle
    resp_lat = 0; resp_data = 32'h3333_0000;
    tick(); t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_grant(1'b0, 32'h0000_0400 + 32'(4 * k), 32'd0, 4'd0, t0 + 1 + k);
      exp_resp(1'b1, 32'h3333_0000, 1'b0, t0 + 1 + k);
    end
    exp_grant(1'b1, 32'h0000_0500, 32'd0, 4'd0, t0 + 5);
    exp_resp(1'b0, 32'h3333_0000, 1'b0, t0 + 5);
    exp_grant(1'b0, 32'h0000_0410, 32'd0, 4'd0, t0 + 6);
    exp_resp(1'b1, 32'h3333_0000, 1'b0, t0 + 6);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0500;
    for (int k = 0; k < 5; k++) begin
      dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = 32'h0000_0400 + 32'(4 * k);
      tick();
      imemory_valid = 1'b0;
    end
    dmemory_valid = 1'b0;
    chk("t3_starve_cleared", 64'(dut.starve_r), 64'd0);
    drain("t3", 40);
    repeat (2) tick();

    // 4: unmapped address, watchdog completes with an error, later stray ready ignored
    resp_lat = -1;
    tick(); t0 = cyc;
    exp_grant(1'b0, 32'hDEAD_0000, 32'd0, 4'd0, t0 + 1);
    exp_resp(1'b1, 32'd0, 1'b1, t0 + 10);
    dmemory_valid = 1'b1; dmemory_instr = 1'b0; dmemory_addr = 32'hDEAD_0000;
    tick();
    dmemory_valid = 1'b0;
    drain("t4", 40);
    stray_check("t4_stray");
    repeat (2) tick();

    // 5: ready lands exactly on the watchdog cycle
    resp_lat = 9; resp_data = 32'hCAFE_F00D;
    tick(); t0 = cyc;
    exp_grant(1'b1, 32'h0000_0700, 32'd0, 4'd0, t0 + 1);
    exp_resp(1'b0, 32'hCAFE_F00D, 1'b0, t0 + 10);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0700;
    tick();
    imemory_valid = 1'b0;
    drain("t5", 40);
    repeat (2) tick();

    // 6: reset in WAIT, late ready ignored, then a fresh request
    resp_lat = -1;
    tick(); t0 = cyc;
    exp_grant(1'b1, 32'h0000_0800, 32'd0, 4'd0, t0 + 1);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0800;
    tick();
    imemory_valid = 1'b0;
    repeat (3) tick();
    chk("t6_in_wait", 64'(dut.state_r), 64'd2);
    reset = 1'b1;
    #1;
    chk("t6_rst_mvalid", 64'(memory_valid), 64'd0);
    chk("t6_rst_maddr", 64'(memory_addr), 64'd0);
    chk("t6_rst_iready", 64'(imemory_ready), 64'd0);
    chk("t6_rst_berr", 64'(bus_error), 64'd0);
    chk("t6_rst_ibuf", 64'(dut.i_full_r), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    stray_check("t6_late");
    resp_lat = 1; resp_data = 32'h600D_600D;
    tick(); t0 = cyc;
    exp_grant(1'b1, 32'h0000_0900, 32'd0, 4'd0, t0 + 1);
    exp_resp(1'b0, 32'h600D_600D, 1'b0, t0 + 2);
    imemory_valid = 1'b1; imemory_instr = 1'b1; imemory_addr = 32'h0000_0900;
    tick();
    imemory_valid = 1'b0;
    drain("t6", 40);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
